gray_code_subtractor: RTL and testbench



---
 rtl/gray_code_subtractor.sv | 99 +++++++++
 tb/tb_gray_code_subtractor.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_code_subtractor.sv
// Three-stage valid/ready pipelined subtractor for Gray-coded operands.
// Computes diff = a - b - bi (Gray in, Gray out) with a binary borrow-out.
module gray_code_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bo
);

    localparam int unsigned SUB_W = WIDTH + 1;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] r;
        r[WIDTH-1] = g[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            r[i] = r[i+1] ^ g[i];
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] v);
        return v ^ (v >> 1);
    endfunction

    logic             v1;
    logic             v2;
    logic             v3;
    logic [WIDTH-1:0] a_bin;
    logic [WIDTH-1:0] b_bin;
    logic             bi1;
    logic [WIDTH-1:0] diff_bin;
    logic             bo2;
    logic             adv1;
    logic             adv2;
    logic             adv3;
    logic [SUB_W-1:0] sub_c;

    // Stage advance chain: an empty stage always advances, so bubbles collapse.
    always_comb begin
        adv3     = !v3 || out_ready;
        adv2     = !v2 || adv3;
        adv1     = !v1 || adv2;
        in_ready = adv1;
        sub_c    = {1'b0, a_bin} - {1'b0, b_bin} - SUB_W'(bi1);
    end

    assign out_valid = v3;

    // S1: decode Gray operands to binary
    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            a_bin <= '0;
            b_bin <= '0;
            bi1   <= 1'b0;
        end else if (adv1) begin
            v1    <= in_valid;
            a_bin <= gray2bin(a);
            b_bin <= gray2bin(b);
            bi1   <= bi;
        end
    end

    // S2: subtract at WIDTH+1 bits; the extra MSB is the borrow
    always_ff @(posedge clk) begin
        if (rst) begin
            v2       <= 1'b0;
            diff_bin <= '0;
            bo2      <= 1'b0;
        end else if (adv2) begin
            v2       <= v1;
            diff_bin <= sub_c[WIDTH-1:0];
            bo2      <= sub_c[WIDTH];
        end
    end

    // S3: re-encode to Gray, hold while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            v3   <= 1'b0;
            diff <= '0;
            bo   <= 1'b0;
        end else if (adv3) begin
            v3   <= v2;
            diff <= bin2gray(diff_bin);
            bo   <= bo2;
        end
    end

endmodule

// File: tb/tb_gray_code_subtractor.sv
// Self-checking bench for gray_code_subtractor: directed steps plus random traffic
// checked against an arithmetic reference model and an in-order scoreboard.
module tb_gray_code_subtractor;

    localparam int unsigned W = 4;
    localparam int unsigned N = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bo;

    gray_code_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bi(bi), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bo(bo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        int unsigned  cyc;
    } exp_t;

    exp_t        sbq[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned cyc   = 0;
    int unsigned n_acc = 0;
    int unsigned n_del = 0;
    bit          lat_chk = 1'b0;
    logic         s_ov, s_ir, s_bo;
    logic [W-1:0] s_diff;

    function automatic logic [W-1:0] to_gray(input int unsigned n);
        return W'(n ^ (n >> 1));
    endfunction

    // Decode by search over all codes rather than by XOR prefix.
    function automatic int unsigned from_gray(input logic [W-1:0] g);
        for (int unsigned n = 0; n < N; n++)
            if (to_gray(n) == g) return n;
        return 0;
    endfunction

    function automatic logic [W:0] model(input logic [W-1:0] ga, input logic [W-1:0] gb, input logic c);
        int d;
        d = int'(from_gray(ga)) - int'(from_gray(gb)) - int'(c);
        return {logic'(d < 0), to_gray(int'((d + int'(N)) % int'(N)))};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive at negedge, sample #1 later, account transfers at the posedge.
    task automatic step(input logic r, input logic iv, input logic [W-1:0] ia,
                        input logic [W-1:0] ib, input logic ibi, input logic ordy);
        logic [W:0] m;
        exp_t e;
        rst = r; in_valid = iv; a = ia; b = ib; bi = ibi; out_ready = ordy;
        #1;
        s_ov = out_valid; s_ir = in_ready; s_diff = diff; s_bo = bo;
        if (!r) begin
            if (out_valid && ordy) begin
                n_del++;
                if (sbq.size() == 0) begin
                    chk("sb_spurious", 32'(1), 32'(0));
                end else begin
                    e = sbq.pop_front();
                    chk("sb_diff", 32'(diff), 32'(e.d));
                    chk("sb_bo", 32'(bo), 32'(e.bo));
                    if (lat_chk) chk("latency", cyc - e.cyc, 32'(3));
                end
            end
            if (iv && in_ready) begin
                n_acc++;
                m = model(ia, ib, ibi);
                e.d = m[W-1:0]; e.bo = m[W]; e.cyc = cyc;
                sbq.push_back(e);
            end
        end
        @(posedge clk);
        cyc++;
        if (r) sbq.delete();
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, '0, '0, 1'b0, ordy);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sbq.size() != 0; i++) idle(1'b1);
        chk("drain_empty", 32'(sbq.size()), 32'(0));
    endtask

    // Issue one op into an empty pipe and capture {bo,diff} when it emerges.
    task automatic single(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibi,
                          output logic [W:0] res, output int unsigned lat);
        bit got = 1'b0;
        res = '0; lat = 0;
        step(1'b0, 1'b1, ia, ib, ibi, 1'b1);
        for (int unsigned i = 1; i < 8 && !got; i++) begin
            idle(1'b1);
            if (s_ov) begin got = 1'b1; res = {s_bo, s_diff}; lat = i; end
        end
        chk("single_seen", 32'(got), 32'(1));
        idle(1'b1);
        chk("single_pulse", 32'(s_ov), 32'(0));
    endtask

    initial begin : main
        logic [W:0]   res;
        int unsigned  lat;
        logic [W-1:0] ha, hb;
        logic [W-1:0] hold_d;
        logic         hold_b;
        int           k;
        int unsigned  acc0;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bi = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
        idle(1'b1);
        chk("rst_out_valid", 32'(s_ov), 32'(0));
        chk("rst_diff", 32'(s_diff), 32'(0));
        chk("rst_bo", 32'(s_bo), 32'(0));
        chk("rst_in_ready", 32'(s_ir), 32'(1));

        lat_chk = 1'b1;
        single(4'b0111, 4'b0010, 1'b0, res, lat);
        chk("tp_5m3", 32'(res), 32'(5'b0_0011));
        chk("tp_5m3_lat", lat, 32'(3));
        single(4'b0010, 4'b0111, 1'b0, res, lat);
        chk("tp_3m5", 32'(res), 32'(5'b1_1001));
        single(4'b0000, 4'b0000, 1'b1, res, lat);
        chk("tp_0m0b", 32'(res), 32'(5'b1_1000));
        single(4'b1101, 4'b1101, 1'b0, res, lat);
        chk("tp_eq", 32'(res), 32'(5'b0_0000));
        single(4'b1101, 4'b1101, 1'b1, res, lat);
        chk("tp_eq_b", 32'(res), 32'({1'b1, to_gray(N - 1)}));

        // Exhaustive back-to-back stream
        for (int unsigned i = 0; i < 2 * N * N; i++) begin
            step(1'b0, 1'b1, W'(i >> (W + 1)), W'(i >> 1), i[0], 1'b1);
            chk("ir_stream", 32'(s_ir), 32'(1));
        end
        drain();

        // Backpressure: six ops, consumer stalled for seven cycles
        acc0 = n_acc; k = 0;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, k < 6, W'(3 * k + 1), W'(k), k[0], 1'b0);
            if (s_ir && k < 6) k++;
            if (i == 3) begin hold_d = s_diff; hold_b = s_bo; end
            if (i > 3) begin
                chk("bp_hold_diff", 32'(s_diff), 32'(hold_d));
                chk("bp_hold_bo", 32'(s_bo), 32'(hold_b));
            end
            if (i >= 3) begin
                chk("bp_out_valid", 32'(s_ov), 32'(1));
                chk("bp_in_ready", 32'(s_ir), 32'(0));
            end
        end
        chk("bp_accepts", n_acc - acc0, 32'(3));
        lat_chk = 1'b0;
        for (int i = 0; i < 20 && k < 6; i++) begin
            step(1'b0, 1'b1, W'(3 * k + 1), W'(k), k[0], 1'b1);
            if (s_ir) k++;
        end
        chk("bp_all_in", 32'(k), 32'(6));
        drain();
        chk("bp_balance", n_acc - n_del, 32'(0));

        // Random valid/ready traffic
        for (int i = 0; i < 10000; i++) begin
            step(1'b0, 1'($urandom_range(1)), W'($urandom), W'($urandom), 1'($urandom_range(1)),
                 1'($urandom_range(1)));
            if (n_acc - n_del > 3) chk("rnd_inflight", n_acc - n_del, 32'(3));
        end
        drain();
        chk("rnd_balance", n_acc - n_del, 32'(0));

        // Reset with three ops in flight; op presented with rst must be dropped
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, W'(i + 5), W'(i), 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'b1111, 4'b0001, 1'b1, 1'b0);
        idle(1'b0);
        chk("mrst_out_valid", 32'(s_ov), 32'(0));
        chk("mrst_diff", 32'(s_diff), 32'(0));
        chk("mrst_bo", 32'(s_bo), 32'(0));
        chk("mrst_in_ready", 32'(s_ir), 32'(1));
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            chk("mrst_no_stale", 32'(s_ov), 32'(0));
        end
        lat_chk = 1'b1;
        ha = 4'b0110; hb = 4'b1100;
        single(ha, hb, 1'b1, res, lat);
        chk("mrst_after", 32'(res), 32'(model(ha, hb, 1'b1)));
        chk("mrst_after_lat", lat, 32'(3));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
